// File: rtl/window_sad_pipe.sv
// Three-stage sum-of-absolute-differences pipeline over a WIN x WIN window pair.
// Define WSAD_TRUNC_EN to clip each per-pixel |l-r| at TRUNC before summation.
module window_sad_pipe #(
    parameter int WIN   = 5,
    parameter int DW    = 8,
    parameter int TRUNC = 32
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic                          i_last,
    input  logic [WIN*WIN*DW-1:0]         i_vector_l,
    input  logic [WIN*WIN*DW-1:0]         i_vector_r,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [DW+$clog2(WIN*WIN)-1:0] o_sad,
    output logic [DW-1:0]                 o_center,
    output logic                          o_last
);
    localparam int N  = WIN * WIN;
    localparam int RW = DW + $clog2(WIN);
    localparam int SW = DW + $clog2(N);
    localparam int CI = (WIN / 2) * WIN + WIN / 2;
    localparam logic [DW-1:0] TRUNC_DW = DW'(TRUNC);
`ifdef WSAD_TRUNC_EN
    localparam bit CLIP = 1'b1;
`else
    localparam bit CLIP = 1'b0;
`endif

    // Handshake: a transfer happens on a rising edge where valid and ready are both
    // high; the whole pipe freezes only while an output is waiting on downstream.
    logic stall;
    assign stall   = o_valid & ~i_ready;
    assign o_ready = ~stall;

    logic          v1, v2;
    logic [DW-1:0] ad_d  [N];
    logic [DW-1:0] ad_q  [N];
    logic [RW-1:0] row_d [WIN];
    logic [RW-1:0] row_q [WIN];
    logic [SW-1:0] total_d;
    logic [DW-1:0] c1, c2;
    logic          l1, l2;

    function automatic logic [DW-1:0] abs_diff(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return (a > b) ? a - b : b - a;
    endfunction

    always_comb begin
        for (int i = 0; i < N; i++) begin
            ad_d[i] = abs_diff(i_vector_l[i*DW +: DW], i_vector_r[i*DW +: DW]);
            if (CLIP && (ad_d[i] > TRUNC_DW)) ad_d[i] = TRUNC_DW;
        end
    end

    always_comb begin
        for (int r = 0; r < WIN; r++) begin
            row_d[r] = '0;
            for (int c = 0; c < WIN; c++) begin
                row_d[r] = row_d[r] + RW'(ad_q[r*WIN + c]);
            end
        end
    end

    // Row sums are at most WIN*(2^DW-1), so SW bits never overflow.
    always_comb begin
        total_d = '0;
        for (int r = 0; r < WIN; r++) begin
            total_d = total_d + SW'(row_q[r]);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            v1       <= 1'b0;
            v2       <= 1'b0;
            o_valid  <= 1'b0;
            ad_q     <= '{default: '0};
            row_q    <= '{default: '0};
            c1       <= '0;
            c2       <= '0;
            l1       <= 1'b0;
            l2       <= 1'b0;
            o_sad    <= '0;
            o_center <= '0;
            o_last   <= 1'b0;
        end else if (!stall) begin
            v1      <= i_valid;
            ad_q    <= ad_d;
            c1      <= i_vector_l[CI*DW +: DW];
            l1      <= i_last;
            v2      <= v1;
            row_q   <= row_d;
            c2      <= c1;
            l2      <= l1;
            o_valid <= v2;
            // Output registers only move on a real result so they hold across bubbles.
            if (v2) begin
                o_sad    <= total_d;
                o_center <= c2;
                o_last   <= l2;
            end
        end
    end
endmodule

// File: tb/tb_window_sad_pipe.sv
// Randomised and directed bench for window_sad_pipe against an arithmetic SAD model.
// Define WSAD_TRUNC_EN for both bench and RTL to cover the clipped build.
module tb_window_sad_pipe;
    localparam int WIN   = 5;
    localparam int DW    = 8;
    localparam int TRUNC = 32;
    localparam int N     = WIN * WIN;
    localparam int SW    = DW + $clog2(N);
    localparam int EW    = SW + DW + 1;
    localparam int CI    = (WIN / 2) * WIN + WIN / 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_valid = 1'b0;
    logic          i_ready = 1'b1;
    logic          i_last = 1'b0;
    logic [N*DW-1:0] vec_l = '0;
    logic [N*DW-1:0] vec_r = '0;
    logic          o_ready, o_valid, o_last;
    logic [SW-1:0] o_sad;
    logic [DW-1:0] o_center;

    int checks = 0;
    int errors = 0;
    int out_cnt = 0;
    int last_cnt = 0;
    logic [EW-1:0] exp_q[$];
    logic          prev_stall = 1'b0;
    logic [EW-1:0] prev_out = '0;
    logic [SW-1:0] held_sad = '0;

    window_sad_pipe #(.WIN(WIN), .DW(DW), .TRUNC(TRUNC)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_last(i_last), .i_vector_l(vec_l), .i_vector_r(vec_r),
        .o_valid(o_valid), .i_ready(i_ready), .o_sad(o_sad),
        .o_center(o_center), .o_last(o_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: plain integer sum of (optionally clipped) absolute differences.
    function automatic logic [EW-1:0] ref_out(input logic [N*DW-1:0] l, input logic [N*DW-1:0] r,
                                             input logic last);
        int sum = 0;
        for (int i = 0; i < N; i++) begin
            int a = int'(l[i*DW +: DW]);
            int b = int'(r[i*DW +: DW]);
            int d = (a > b) ? a - b : b - a;
`ifdef WSAD_TRUNC_EN
            if (d > TRUNC) d = TRUNC;
`endif
            sum += d;
        end
        return {last, l[CI*DW +: DW], SW'(sum)};
    endfunction

    function automatic logic [N*DW-1:0] fill(input int val);
        logic [N*DW-1:0] v;
        for (int i = 0; i < N; i++) v[i*DW +: DW] = DW'(val);
        return v;
    endfunction

    function automatic logic [N*DW-1:0] rand_vec();
        logic [N*DW-1:0] v;
        for (int i = 0; i < N; i++) v[i*DW +: DW] = DW'($urandom);
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        check("drain", exp_q.size(), 0);
        repeat (2) step();
    endtask

    // Scoreboard and protocol monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            prev_stall = 1'b0;
            held_sad   = '0;
            check("rst_ready", o_ready, 1);
            check("rst_valid", o_valid, 0);
        end else begin
            check("ready", o_ready, !(o_valid && !i_ready));
            if (prev_stall) check("stall_hold", {o_last, o_center, o_sad}, prev_out);
            if (!o_valid) check("idle_hold", o_sad, held_sad);
            else held_sad = o_sad;
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) check("spurious_out", 1, 0);
                else check("out", {o_last, o_center, o_sad}, exp_q.pop_front());
                out_cnt++;
                if (o_last) last_cnt++;
            end
            if (i_valid && o_ready) exp_q.push_back(ref_out(vec_l, vec_r, i_last));
            prev_stall = o_valid && !i_ready;
            prev_out   = {o_last, o_center, o_sad};
        end
    end

    initial begin
        logic [EW-1:0] e0;
        int cnt0, n;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_sad", o_sad, 0);
        check("rst_center", o_center, 0);
        check("rst_last", o_last, 0);
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", o_ready, 1);
        step();

        // Single window latency: 200 vs 50
        vec_l = fill(200);
        vec_r = fill(50);
        i_valid = 1'b1;
        @(negedge clk);
        check("lat_accept", o_ready, 1);
        step();
        i_valid = 1'b0;
        @(negedge clk); check("lat_c1", o_valid, 0);
        @(negedge clk); check("lat_c2", o_valid, 0);
        @(negedge clk); check("lat_c3", o_valid, 1);
`ifdef WSAD_TRUNC_EN
        check("sad_200_50", o_sad, 800);
`else
        check("sad_200_50", o_sad, 3750);
`endif
        step();
        wait_drain(10);

        // Boundaries: equal windows and the maximum difference
        vec_l = rand_vec(); vec_r = vec_l; i_valid = 1'b1; step();
        vec_l = fill(255); vec_r = fill(0); step();
        vec_l = fill(0); vec_r = fill(255); step();
        i_valid = 1'b0;
        wait_drain(10);

        // Ten back-to-back windows giving SAD 0..9
        for (int j = 0; j < 13; j++) begin
            if (j < 10) begin
                vec_r = rand_vec();
                vec_r[DW-1:0] = '0;
                vec_l = vec_r;
                vec_l[DW-1:0] = DW'(j);
                i_valid = 1'b1;
            end else begin
                i_valid = 1'b0;
            end
            @(negedge clk);
            check("b2b_ready", o_ready, 1);
            check("b2b_valid", o_valid, (j >= 3) ? 1 : 0);
            if (j >= 3) check("b2b_sad", o_sad, j - 3);
            step();
        end
        wait_drain(10);

        // Four-cycle downstream stall with three windows in flight
        for (int j = 0; j < 3; j++) begin
            vec_l = rand_vec(); vec_r = rand_vec(); i_valid = 1'b1;
            if (j == 0) e0 = ref_out(vec_l, vec_r, 1'b0);
            step();
        end
        i_ready = 1'b0;
        vec_l = rand_vec(); vec_r = rand_vec();
        repeat (4) begin
            @(negedge clk);
            check("stall_ready", o_ready, 0);
            check("stall_valid", o_valid, 1);
            check("stall_sad", o_sad, e0[SW-1:0]);
            step();
        end
        i_ready = 1'b1;
        i_valid = 1'b0;
        cnt0 = out_cnt;
        wait_drain(20);
        check("stall_count", out_cnt - cnt0, 3);

        // Line-end flag and centre pixel alignment
        cnt0 = last_cnt;
        for (int j = 0; j < 5; j++) begin
            vec_l = rand_vec(); vec_r = rand_vec();
            vec_l[CI*DW +: DW] = DW'(10 * (j + 1));
            i_last = (j == 3);
            i_valid = 1'b1;
            step();
        end
        i_valid = 1'b0;
        i_last = 1'b0;
        wait_drain(10);
        check("last_count", last_cnt - cnt0, 1);

        // Reset one cycle after two transfers discards both
        cnt0 = out_cnt;
        for (int j = 0; j < 2; j++) begin
            vec_l = rand_vec(); vec_r = rand_vec(); i_valid = 1'b1;
            step();
        end
        i_valid = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            check("flush_valid", o_valid, 0);
            step();
        end
        check("flush_count", out_cnt - cnt0, 0);

        // Asynchronous clear of a held output
        vec_l = fill(200); vec_r = fill(50); i_valid = 1'b1; i_ready = 1'b0;
        step();
        i_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!o_valid && n < 10);
        check("async_pre_valid", o_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_valid", o_valid, 0);
        check("async_sad", o_sad, 0);
        check("async_ready", o_ready, 1);
        @(negedge clk);
        step();
        rst_n = 1'b1;
        i_ready = 1'b1;
        step();

        // Random traffic with random backpressure
        for (int j = 0; j < 400; j++) begin
            i_valid = ($urandom_range(0, 3) != 0);
            i_ready = ($urandom_range(0, 3) != 0);
            i_last  = ($urandom_range(0, 7) == 0);
            vec_l = rand_vec();
            if ($urandom_range(0, 1) == 0) begin
                vec_r = rand_vec();
            end else begin
                vec_r = vec_l;
                vec_r[$urandom_range(0, N - 1)*DW +: DW] = DW'($urandom);
            end
            step();
        end
        i_valid = 1'b0;
        i_last = 1'b0;
        i_ready = 1'b1;
        wait_drain(50);
        check("final_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/window_sad_pipe.md
WINDOW_SAD_PIPE -- requirements
Module: window_sad_pipe

Interface
REQ-001 Parameter WIN, default 5: window side length; odd, legal range 3..9.
REQ-002 Parameter DW, default 8: pixel width in bits.
REQ-003 Parameter TRUNC, default 32: per-pixel absolute-difference clip level; used only when WSAD_TRUNC_EN is defined.
REQ-004 Derived localparam SW = DW + $clog2(WIN*WIN): SAD width; 13 with the defaults.
REQ-005 i_clk  in  1  the single clock; all state SHALL be updated on its rising edge.
REQ-006 i_rst_n  in  1  reset, asynchronous, active-low.
REQ-007 i_valid  in  1  input window pair is valid this cycle.
REQ-008 o_ready  out  1  block accepts input this cycle.
REQ-009 i_last  in  1  sideband flag marking the last window of an image line.
REQ-010 i_vector_l  in  WIN*WIN*DW  left window, packed; element (r,c) at bits [(r*WIN+c)*DW +: DW].
REQ-011 i_vector_r  in  WIN*WIN*DW  right window, same packing as i_vector_l.
REQ-012 o_valid  out  1  o_sad, o_center and o_last are valid this cycle.
REQ-013 i_ready  in  1  downstream accepts the output this cycle.
REQ-014 o_sad  out  SW  sum of absolute differences over the window.
REQ-015 o_center  out  DW  left-window centre pixel (WIN/2, WIN/2), aligned with o_sad.
REQ-016 o_last  out  1  i_last delayed to align with o_sad.

Function
REQ-017 An input transfer SHALL occur when i_valid and o_ready are both high; an output transfer SHALL occur when o_valid and i_ready are both high.
REQ-018 Stage 1 SHALL register, per element, |l-r|, computed unsigned as (l>r) ? l-r : r-l; the result SHALL be DW bits.
REQ-019 Stage 2 SHALL register WIN row sums, each DW+$clog2(WIN) bits.
REQ-020 Stage 3 SHALL register the total of the row sums into o_sad, SW bits; the sum SHALL never overflow.
REQ-021 o_center and o_last SHALL travel through registers that advance with the stage-valid bits.
REQ-022 Latency SHALL be 3 cycles from input transfer to o_valid when the pipeline is not stalled.
REQ-023 Throughput SHALL be one window per cycle.
REQ-024 Stall condition: stall = o_valid & ~i_ready; during a stall all stage registers and valid bits SHALL hold.
REQ-025 o_ready SHALL equal ~stall, a combinational function of o_valid and i_ready only.
REQ-026 Inputs presented while o_ready is low SHALL be ignored.
REQ-027 Stage-valid bits SHALL advance when not stalled, and bubbles SHALL propagate as valid=0.
REQ-028 Data registers of an invalid stage MAY update, but o_sad, o_center and o_last SHALL hold while o_valid is low.
REQ-029 An output transfer and an input transfer in the same cycle SHALL both complete, with no loss and no duplication.
REQ-030 o_sad with all-equal windows SHALL be 0; the maximum is WIN*WIN*(2^DW-1) (6375 with the defaults).

Reset
REQ-031 When i_rst_n is low, all stage-valid bits, o_valid, o_sad, o_center, o_last and all intermediate registers SHALL clear to 0 immediately, without waiting for a clock edge.
REQ-032 Reset asserted mid-operation SHALL discard all in-flight windows; no output SHALL appear for data accepted before reset.
REQ-033 o_ready SHALL be 1 while reset is asserted and on the first cycle after reset is released.

Configuration
REQ-034 Macro WSAD_TRUNC_EN, when defined: stage 1 SHALL store min(|l-r|, TRUNC) (truncated AD), with TRUNC compared at DW bits.
REQ-035 When WSAD_TRUNC_EN is not defined: stage 1 SHALL store the unclipped |l-r|, and TRUNC SHALL have no effect.
REQ-036 Latency, handshake and output widths SHALL be identical in both builds.

Verification
REQ-037 Scenario: l all 200, r all 50, WIN=5, DW=8, i_ready=1, no macro -> o_sad=3750, o_valid high exactly 3 cycles after the transfer.
REQ-038 Scenario: same stimulus with WSAD_TRUNC_EN defined and TRUNC=32 -> o_sad=800.
REQ-039 Scenario: 10 back-to-back windows with l(0,0)=k and the rest of l equal to r, k=0..9, i_ready=1 -> o_sad sequence 0..9 on consecutive cycles, o_ready constantly 1.
REQ-040 Scenario: i_ready held 0 for 4 cycles while 3 windows are in flight -> o_ready=0 while stalled, o_sad held, then 3 outputs in order with none lost or duplicated.
REQ-041 Scenario: i_rst_n pulsed low 1 cycle after 2 transfers -> o_valid stays 0 and no output from those windows appears.
REQ-042 Scenario: i_last=1 on the 4th of 5 windows, and centre pixel values 10,20,30,40,50 -> o_last=1 only with the 4th output, and o_center matches each window.
